sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
- Converts the single SRAM-like master port driven by a cache miss/write-back engine into single-beat AXI read and write transactions.
- Sits directly downstream of the cache block, between the cache's SRAM-like bus and the system AXI interconnect.
- Supports one outstanding transaction at a time, with no reordering.

Parameters:
AXI_ID, 4'h0, ID value driven on arid/awid; responses are not ID-checked.
ID_W, 4, width of arid/awid.

Ports:
clk  in  1  single clock
rst_n  in  1  reset; asynchronous, active-low
sram_like_req  in  1  request; held by master until addr_ok
sram_like_wr  in  1  1=write, 0=read
sram_like_size  in  2  00 byte, 01 half, 10 word
sram_like_addr  in  32  byte address
sram_like_wdata  in  32  write data, lane-aligned to address
sram_like_rdata  out  32  read data, valid with data_ok
sram_like_addr_ok  out  1  request accepted (1-cycle pulse)
sram_like_data_ok  out  1  transaction finished (1-cycle pulse)
arid/awid  out  ID_W  = AXI_ID
araddr/awaddr  out  32  latched address
arlen/awlen  out  4  always 0
arsize/awsize  out  3  {1'b0, latched size}
arvalid/awvalid  out  1  address valid
arready/awready  in  1  address ready
rdata  in  32  read data
rresp  in  2  ignored
rlast  in  1  ignored (always single beat)
rvalid  in  1
rready  out  1
wdata  out  32  latched wdata
wstrb  out  4  derived from size and addr[1:0]
wlast  out  1  = wvalid
wvalid  out  1
wready  in  1
bresp  in  2  ignored
bvalid  in  1
bready  out  1

Behaviour:
- States: IDLE, AR, R, AWW, B. Async reset -> IDLE; all valid/ready/ok outputs 0; latched addr/wdata/size 0.
- addr_ok = (state==IDLE) & req, combinational. On that cycle: latch wr/size/addr/wdata; next state AR (read) or AWW (write). Requests arriving while not IDLE see addr_ok=0 and are held by the master.
- AR: arvalid=1 until arvalid&arready, then R. araddr is not modified.
- R: rready=1. data_ok = rvalid (combinational); rdata passes straight through. Next state is IDLE on rvalid.
- Minimum read latency: req at cycle 0, arvalid cycle 1, data_ok cycle 2.
- AWW: awvalid and wvalid both rise in the first AWW cycle. Each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - Move to B in the cycle the second handshake completes; both in the same cycle is legal.
  - Flags clear on leaving AWW.
- B: bready=1. data_ok = bvalid. Next state is IDLE on bvalid.
- wstrb rules:
  - byte: 0001 << addr[1:0]
  - half: addr[1]? 1100 : 0011
  - word: 1111
  - size 11 is treated as word.
- Address is never realigned; the master supplies a word-aligned address for word accesses.
- addr_ok and data_ok never both 1 in one cycle.
- Reset mid-transaction abandons the AXI transaction; the interconnect is reset jointly.

Optional Feature:
BRIDGE_WR_EARLY_ACK_EN
- Defined:
  - A write's data_ok pulses in the cycle both AW and W have completed, instead of on bvalid. The state returns to IDLE and sets b_pending.
  - bready=1 while b_pending; b_pending clears on bvalid.
  - While b_pending, addr_ok is forced to 0 for all requests.
  - A bvalid arriving in the same cycle data_ok pulses is legal; b_pending then never sets.
- Undefined: behaviour as above, and state B is used.

Decomposition:
- Package includes: state enum, AXI size/resp localparams, and a function mapping (size, addr[1:0]) to wstrb. The cache reuses the same mask function.
- No sub-module; a single flat FSM.

Test Plan:
- Read hit path: req=1, wr=0, size=10, addr=0x1FC0_0004. Expect addr_ok at cycle 0, araddr=0x1FC0_0004 with arsize=010 at cycle 1. arready cycle 1, rvalid cycle 3 with rdata=0xDEADBEEF -> data_ok=1 and rdata=0xDEADBEEF at cycle 3 only.
- Byte write: size=00, addr=0x...03, wdata=0xAB000000 -> wstrb=1000, awsize=000. awready at cycle 2, wready at cycle 4 -> awvalid drops after cycle 2, wvalid after cycle 4. bvalid at cycle 6 -> data_ok at cycle 6.
- AW/W same-cycle handshake: awready=wready=1 at cycle 1 -> B at cycle 2.
- Back-to-back: second req asserted during R -> addr_ok=0 until IDLE, then accepted in the first IDLE cycle.
- Async reset: rst_n low mid-R -> arvalid/rready/data_ok go 0 immediately, state IDLE; req after release gets addr_ok.
- Early ack (macro defined): write with AW/W done at cycle 1 -> data_ok at cycle 1. Read req at cycle 2 -> addr_ok held 0 until the bvalid cycle (cycle 5), then accepted in cycle 6.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types for the SRAM-like to AXI bridge: FSM states, AXI size/resp
// codes and the byte-lane mask helper (the cache uses the same mask).
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] AXI_LEN_1 = 4'h0;

    // Byte-lane mask for an access; size 11 falls through to a full word.
    function automatic logic [3:0] wstrb_of(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] m;
        unique case (1'b1)
            size == SIZE_BYTE: m = 4'b0001 << off;
            size == SIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            default:           m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Bus bundles for the bridge: the cache-side SRAM-like port and the
// single-beat AXI port. master/slave modports give each side's view.
interface sram_like_if;
    logic        sram_like_req;
    logic        sram_like_wr;
    logic [1:0]  sram_like_size;
    logic [31:0] sram_like_addr;
    logic [31:0] sram_like_wdata;
    logic [31:0] sram_like_rdata;
    logic        sram_like_addr_ok;
    logic        sram_like_data_ok;

    modport master (
        output sram_like_req, sram_like_wr, sram_like_size,
        output sram_like_addr, sram_like_wdata,
        input  sram_like_rdata, sram_like_addr_ok, sram_like_data_ok
    );

    modport slave (
        input  sram_like_req, sram_like_wr, sram_like_size,
        input  sram_like_addr, sram_like_wdata,
        output sram_like_rdata, sram_like_addr_ok, sram_like_data_ok
    );
endinterface

interface axi_if #(parameter int ID_W = 4);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arvalid, input arready,
        input  rdata, rresp, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready,
        input  awid, awaddr, awlen, awsize, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// SRAM-like to AXI bridge: one outstanding single-beat read or write.
// Ports: clk, rst_n (async, active-low), sram (sram_like_if.slave),
// axi (axi_if.master). Params: ID_W, AXI_ID (driven on arid/awid).
// Macro BRIDGE_WR_EARLY_ACK_EN: ack writes once AW and W are done and
// drain the B response in the background (b_pending).
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int            ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_like_if.slave  sram,
    axi_if.master       axi
);

    state_e      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        arvalid_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        rready_q;
    logic        bready_q;
    logic        aw_done;
    logic        w_done;
    logic        b_pending;

    logic aw_hs, w_hs, aw_fin, w_fin, wr_fin, addr_ok;

    assign aw_hs  = awvalid_q & axi.awready;
    assign w_hs   = wvalid_q & axi.wready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;
    assign wr_fin = (state == S_AWW) & aw_fin & w_fin;

    assign addr_ok = (state == S_IDLE) & sram.sram_like_req & ~b_pending;

    assign sram.sram_like_addr_ok = addr_ok;
    assign sram.sram_like_rdata   = axi.rdata;
`ifdef BRIDGE_WR_EARLY_ACK_EN
    assign sram.sram_like_data_ok = ((state == S_R) & axi.rvalid) | wr_fin;
`else
    assign sram.sram_like_data_ok = ((state == S_R) & axi.rvalid)
                                  | ((state == S_B) & axi.bvalid);
`endif

    assign axi.arid    = AXI_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = AXI_LEN_1;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = AXI_LEN_1;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_of(size_q, addr_q[1:0]);
    assign axi.wlast   = wvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

`ifndef BRIDGE_WR_EARLY_ACK_EN
    assign b_pending = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
`ifdef BRIDGE_WR_EARLY_ACK_EN
            b_pending <= 1'b0;
`endif
        end else begin
`ifdef BRIDGE_WR_EARLY_ACK_EN
            if (b_pending && axi.bvalid) begin
                b_pending <= 1'b0;
                bready_q  <= 1'b0;
            end
`endif
            unique case (state)
                S_IDLE: if (addr_ok) begin
                    addr_q  <= sram.sram_like_addr;
                    wdata_q <= sram.sram_like_wdata;
                    size_q  <= sram.sram_like_size;
                    if (sram.sram_like_wr) begin
                        state     <= S_AWW;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
`ifdef BRIDGE_WR_EARLY_ACK_EN
                        // Ready for B from the start so a response landing
                        // with the final handshake is not dropped.
                        bready_q  <= 1'b1;
`endif
                    end else begin
                        state     <= S_AR;
                        arvalid_q <= 1'b1;
                    end
                end
                S_AR: if (axi.arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state     <= S_R;
                end
                S_R: if (axi.rvalid) begin
                    rready_q <= 1'b0;
                    state    <= S_IDLE;
                end
                S_AWW: if (aw_fin && w_fin) begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
`ifdef BRIDGE_WR_EARLY_ACK_EN
                    state     <= S_IDLE;
                    b_pending <= ~axi.bvalid;
                    bready_q  <= ~axi.bvalid;
`else
                    state     <= S_B;
                    bready_q  <= 1'b1;
`endif
                end else begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                end
                S_B: if (axi.bvalid) begin
                    bready_q <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: directed scenarios plus random
// transactions against a word-array memory model of the AXI target.
module tb_sram_axi_bridge;

`ifdef BRIDGE_WR_EARLY_ACK_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_like_if s();
    axi_if #(.ID_W(4)) a();

    sram_axi_bridge #(.ID_W(4), .AXI_ID(4'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sram  (s),
        .axi   (a)
    );

    int cmp_n = 0;
    int err_n = 0;

    // slv_mem: what the AXI target holds (written via DUT wstrb/wdata).
    // ref_mem: what the cache intended (written via the access rules).
    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];

    function automatic logic [3:0] exp_mask(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'(1 << off);
            2'd1:    return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit wr, input logic [1:0] sz,
                             input logic [31:0] ad, input logic [31:0] wd);
        s.sram_like_req   = 1'b1;
        s.sram_like_wr    = wr;
        s.sram_like_size  = sz;
        s.sram_like_addr  = ad;
        s.sram_like_wdata = wd;
    endtask

    task automatic drop_req();
        s.sram_like_req   = 1'b0;
        s.sram_like_wr    = 1'b0;
        s.sram_like_size  = 2'($urandom);
        s.sram_like_addr  = $urandom;
        s.sram_like_wdata = $urandom;
    endtask

    // d1: AR/AW ready delay, d2: R/W delay, d3: B delay (cycles).
    task automatic do_txn(input bit wr, input logic [1:0] sz,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input int d1, input int d2, input int d3,
                          input string tag);
        logic [3:0]  m;
        logic [3:0]  cap_strb;
        logic [31:0] cap_addr;
        logic [31:0] cap_data;
        logic [31:0] exp_rd;
        int last;
        cap_strb = '0;
        cap_addr = '0;
        cap_data = '0;
        drive_req(wr, sz, ad, wd);
        #1;
        cmp_n++;
        if (s.sram_like_addr_ok !== 1'b1) begin
            err_n++;
            $display("FAIL %s addr_ok: got %b want 1", tag, s.sram_like_addr_ok);
        end
        step();
        drop_req();
        if (!wr) begin
            for (int c = 0; c <= d1; c++) begin
                a.arready = (c == d1);
                #1;
                cmp_n++;
                if (a.arvalid !== 1'b1 || a.araddr !== ad || a.arsize !== {1'b0, sz}
                    || a.arlen !== 4'h0 || a.arid !== 4'h0 || s.sram_like_data_ok !== 1'b0) begin
                    err_n++;
                    $display("FAIL %s ar: got v=%b a=%h sz=%h len=%h id=%h dok=%b want v=1 a=%h sz=%h",
                             tag, a.arvalid, a.araddr, a.arsize, a.arlen, a.arid,
                             s.sram_like_data_ok, ad, {1'b0, sz});
                end
                step();
            end
            a.arready = 1'b0;
            exp_rd = ref_mem[ad[5:2]];
            for (int c = 0; c <= d2; c++) begin
                a.rvalid = (c == d2);
                a.rdata  = (c == d2) ? slv_mem[ad[5:2]] : $urandom;
                #1;
                cmp_n++;
                if (a.rready !== 1'b1 || s.sram_like_data_ok !== (c == d2)
                    || a.arvalid !== 1'b0 || s.sram_like_addr_ok !== 1'b0) begin
                    err_n++;
                    $display("FAIL %s r: got rready=%b dok=%b arv=%b aok=%b want 1 %b 0 0",
                             tag, a.rready, s.sram_like_data_ok, a.arvalid,
                             s.sram_like_addr_ok, (c == d2));
                end
                if (c == d2) begin
                    cmp_n++;
                    if (s.sram_like_rdata !== exp_rd) begin
                        err_n++;
                        $display("FAIL %s rdata: got %h want %h", tag, s.sram_like_rdata, exp_rd);
                    end
                end
                step();
            end
            a.rvalid = 1'b0;
        end else begin
            m = exp_mask(sz, ad[1:0]);
            last = (d1 > d2) ? d1 : d2;
            for (int c = 0; c <= last; c++) begin
                a.awready = (c == d1);
                a.wready  = (c == d2);
                #1;
                cmp_n++;
                if (a.awvalid !== (c <= d1) || a.wvalid !== (c <= d2) || a.wlast !== (c <= d2)
                    || s.sram_like_data_ok !== (EARLY && c == last)) begin
                    err_n++;
                    $display("FAIL %s aww c=%0d: got awv=%b wv=%b wl=%b dok=%b want %b %b %b %b",
                             tag, c, a.awvalid, a.wvalid, a.wlast, s.sram_like_data_ok,
                             (c <= d1), (c <= d2), (c <= d2), (EARLY && c == last));
                end
                if (c == d1) begin
                    cap_addr = a.awaddr;
                    cmp_n++;
                    if (a.awaddr !== ad || a.awsize !== {1'b0, sz} || a.awlen !== 4'h0
                        || a.awid !== 4'h0) begin
                        err_n++;
                        $display("FAIL %s aw: got a=%h sz=%h len=%h id=%h want a=%h sz=%h",
                                 tag, a.awaddr, a.awsize, a.awlen, a.awid, ad, {1'b0, sz});
                    end
                end
                if (c == d2) begin
                    cap_strb = a.wstrb;
                    cap_data = a.wdata;
                    cmp_n++;
                    if (a.wdata !== wd || a.wstrb !== m) begin
                        err_n++;
                        $display("FAIL %s w: got d=%h s=%b want d=%h s=%b",
                                 tag, a.wdata, a.wstrb, wd, m);
                    end
                end
                step();
            end
            a.awready = 1'b0;
            a.wready  = 1'b0;
            for (int b = 0; b < 4; b++) begin
                if (cap_strb[b]) slv_mem[cap_addr[5:2]][8*b +: 8] = cap_data[8*b +: 8];
                if (m[b]) ref_mem[ad[5:2]][8*b +: 8] = wd[8*b +: 8];
            end
            for (int c = 0; c <= d3; c++) begin
                a.bvalid = (c == d3);
                #1;
                cmp_n++;
                if (a.bready !== 1'b1 || s.sram_like_data_ok !== (!EARLY && c == d3)
                    || a.awvalid !== 1'b0 || a.wvalid !== 1'b0) begin
                    err_n++;
                    $display("FAIL %s b: got bready=%b dok=%b awv=%b wv=%b want 1 %b 0 0",
                             tag, a.bready, s.sram_like_data_ok, a.awvalid, a.wvalid,
                             (!EARLY && c == d3));
                end
                step();
            end
            a.bvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        cmp_n++;
        if (s.sram_like_addr_ok !== 1'b0 || s.sram_like_data_ok !== 1'b0
            || a.arvalid !== 1'b0 || a.awvalid !== 1'b0 || a.wvalid !== 1'b0
            || a.rready !== 1'b0 || a.bready !== 1'b0) begin
            err_n++;
            $display("FAIL reset ctl: aok=%b dok=%b arv=%b awv=%b wv=%b rr=%b br=%b want all 0",
                     s.sram_like_addr_ok, s.sram_like_data_ok, a.arvalid, a.awvalid,
                     a.wvalid, a.rready, a.bready);
        end
        cmp_n++;
        if (a.araddr !== 32'h0 || a.wdata !== 32'h0 || a.awsize !== 3'b000
            || a.wstrb !== 4'b0001) begin
            err_n++;
            $display("FAIL reset data: addr=%h wdata=%h size=%b strb=%b want 0 0 000 0001",
                     a.araddr, a.wdata, a.awsize, a.wstrb);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_hit();
        slv_mem[1] = 32'hDEADBEEF;
        ref_mem[1] = 32'hDEADBEEF;
        do_txn(1'b0, 2'b10, 32'h1FC0_0004, 32'h0, 0, 1, 0, "read_hit");
    endtask

    task automatic test_byte_write();
        do_txn(1'b1, 2'b00, 32'h1FC0_0003, 32'hAB00_0000, 1, 3, 1, "byte_write");
        do_txn(1'b0, 2'b10, 32'h1FC0_0000, 32'h0, 0, 0, 0, "byte_write_rb");
    endtask

    task automatic test_same_cycle();
        do_txn(1'b1, 2'b01, 32'h8000_0016, 32'h5A5A_0000, 0, 0, 0, "aw_w_same");
        do_txn(1'b1, 2'b10, 32'h8000_0018, 32'h1234_5678, 2, 0, 2, "w_first");
        do_txn(1'b0, 2'b10, 32'h8000_0014, 32'h0, 1, 0, 0, "same_rb");
    endtask

    task automatic test_back_to_back();
        drive_req(1'b0, 2'b10, 32'h8000_0008, 32'h0);
        #1;
        cmp_n++;
        if (s.sram_like_addr_ok !== 1'b1) begin
            err_n++;
            $display("FAIL b2b first addr_ok: got %b want 1", s.sram_like_addr_ok);
        end
        step();
        drive_req(1'b0, 2'b10, 32'h8000_000C, 32'h0);
        a.arready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            a.rvalid = (c == 2);
            a.rdata  = slv_mem[2];
            #1;
            cmp_n++;
            if (s.sram_like_addr_ok !== 1'b0 || s.sram_like_data_ok !== (c == 2)) begin
                err_n++;
                $display("FAIL b2b busy c=%0d: got aok=%b dok=%b want 0 %b",
                         c, s.sram_like_addr_ok, s.sram_like_data_ok, (c == 2));
            end
            if (c == 2) begin
                cmp_n++;
                if (s.sram_like_rdata !== ref_mem[2]) begin
                    err_n++;
                    $display("FAIL b2b rdata: got %h want %h", s.sram_like_rdata, ref_mem[2]);
                end
            end
            step();
            a.arready = 1'b0;
        end
        a.rvalid = 1'b0;
        do_txn(1'b0, 2'b10, 32'h8000_000C, 32'h0, 0, 0, 0, "b2b_second");
    endtask

    task automatic test_async_reset();
        drive_req(1'b0, 2'b10, 32'h8000_0020, 32'h0);
        step();
        drop_req();
        a.arready = 1'b1;
        step();
        a.arready = 1'b0;
        a.rvalid  = 1'b1;
        #1;
        cmp_n++;
        if (a.rready !== 1'b1 || s.sram_like_data_ok !== 1'b1) begin
            err_n++;
            $display("FAIL arst pre: got rready=%b dok=%b want 1 1", a.rready, s.sram_like_data_ok);
        end
        #1;
        rst_n = 1'b0;
        #1;
        cmp_n++;
        if (a.rready !== 1'b0 || a.arvalid !== 1'b0 || s.sram_like_data_ok !== 1'b0
            || a.araddr !== 32'h0) begin
            err_n++;
            $display("FAIL arst: got rready=%b arv=%b dok=%b addr=%h want 0 0 0 0",
                     a.rready, a.arvalid, s.sram_like_data_ok, a.araddr);
        end
        a.rvalid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        do_txn(1'b0, 2'b10, 32'h8000_0024, 32'h0, 0, 0, 0, "arst_after");
    endtask

`ifdef BRIDGE_WR_EARLY_ACK_EN
    task automatic test_early_ack();
        drive_req(1'b1, 2'b10, 32'h8000_0030, 32'hCAFE_F00D);
        step();
        drop_req();
        a.awready = 1'b1;
        a.wready  = 1'b1;
        #1;
        cmp_n++;
        if (s.sram_like_data_ok !== 1'b1) begin
            err_n++;
            $display("FAIL early dok: got %b want 1", s.sram_like_data_ok);
        end
        step();
        a.awready = 1'b0;
        a.wready  = 1'b0;
        slv_mem[12] = 32'hCAFE_F00D;
        ref_mem[12] = 32'hCAFE_F00D;
        drive_req(1'b0, 2'b10, 32'h8000_0030, 32'h0);
        for (int c = 2; c <= 5; c++) begin
            a.bvalid = (c == 5);
            #1;
            cmp_n++;
            if (s.sram_like_addr_ok !== 1'b0 || a.bready !== 1'b1 || s.sram_like_data_ok !== 1'b0) begin
                err_n++;
                $display("FAIL early hold c=%0d: got aok=%b bready=%b dok=%b want 0 1 0",
                         c, s.sram_like_addr_ok, a.bready, s.sram_like_data_ok);
            end
            step();
        end
        a.bvalid = 1'b0;
        do_txn(1'b0, 2'b10, 32'h8000_0030, 32'h0, 0, 0, 0, "early_rd");
        drive_req(1'b1, 2'b00, 32'h8000_0031, 32'h0000_7700);
        step();
        drop_req();
        a.awready = 1'b1;
        a.wready  = 1'b1;
        a.bvalid  = 1'b1;
        #1;
        cmp_n++;
        if (s.sram_like_data_ok !== 1'b1 || a.bready !== 1'b1) begin
            err_n++;
            $display("FAIL early same-b: got dok=%b bready=%b want 1 1", s.sram_like_data_ok, a.bready);
        end
        step();
        a.awready = 1'b0;
        a.wready  = 1'b0;
        a.bvalid  = 1'b0;
        slv_mem[12][15:8] = 8'h77;
        ref_mem[12][15:8] = 8'h77;
        do_txn(1'b0, 2'b10, 32'h8000_0030, 32'h0, 0, 0, 0, "early_same_rd");
    endtask
`endif

    task automatic test_random();
        bit          wr;
        logic [1:0]  sz;
        logic [1:0]  off;
        logic [31:0] ad;
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom);
            sz = 2'($urandom);
            case (sz)
                2'd0:    off = 2'($urandom);
                2'd1:    off = {1'($urandom), 1'b0};
                default: off = 2'd0;
            endcase
            ad = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'(off);
            do_txn(wr, sz, ad, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), "random");
        end
        for (int i = 0; i < 16; i++)
            do_txn(1'b0, 2'b10, 32'h8000_0000 | 32'(i << 2), 32'h0, 0, 0, 0, "sweep");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        drop_req();
        s.sram_like_addr = '0;
        a.arready = 1'b0;
        a.rdata   = '0;
        a.rresp   = '0;
        a.rlast   = 1'b1;
        a.rvalid  = 1'b0;
        a.awready = 1'b0;
        a.wready  = 1'b0;
        a.bresp   = '0;
        a.bvalid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end
        step();
        test_reset();
        test_read_hit();
        test_byte_write();
        test_same_cycle();
        test_back_to_back();
        test_async_reset();
`ifdef BRIDGE_WR_EARLY_ACK_EN
        test_early_ack();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
